// File: rtl/game_vga_timing.sv
// VGA raster timing source: pixel divider, hpos/vpos counters, sync pulses,
// display window and line/frame strobes, all registered with zero skew.
module game_vga_timing #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 1,
    parameter int POS_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 display_on,
    output logic [POS_WIDTH-1:0] hpos,
    output logic [POS_WIDTH-1:0] vpos,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [7:0]           frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_WIDTH-1:0] H_LAST   = POS_WIDTH'(H_TOTAL - 1);
    localparam logic [POS_WIDTH-1:0] V_LAST   = POS_WIDTH'(V_TOTAL - 1);
    localparam logic [POS_WIDTH-1:0] H_VIS    = POS_WIDTH'(H_DISPLAY);
    localparam logic [POS_WIDTH-1:0] V_VIS    = POS_WIDTH'(V_DISPLAY);
    localparam logic [POS_WIDTH-1:0] HS_FIRST = POS_WIDTH'(H_DISPLAY + H_FRONT);
    localparam logic [POS_WIDTH-1:0] HS_LAST  = POS_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_WIDTH-1:0] VS_FIRST = POS_WIDTH'(V_DISPLAY + V_FRONT);
    localparam logic [POS_WIDTH-1:0] VS_LAST  = POS_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]     r_div;
    logic [POS_WIDTH-1:0] r_hpos;
    logic [POS_WIDTH-1:0] r_vpos;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_display_on;
    logic                 r_line_start;
    logic                 r_frame_start;
    logic [7:0]           r_frame_cnt;

    logic                 w_tick;
    logic [POS_WIDTH-1:0] w_h_next;
    logic [POS_WIDTH-1:0] w_v_next;
    logic                 w_line_edge;
    logic                 w_frame_edge;

    assign w_tick = (r_div == DIV_LAST);

    always_comb begin
        w_h_next = r_hpos;
        w_v_next = r_vpos;
        if (w_tick) begin
            if (r_hpos == H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_vpos == V_LAST) ? '0 : r_vpos + POS_WIDTH'(1);
            end else begin
                w_h_next = r_hpos + POS_WIDTH'(1);
            end
        end
    end

    // Strobes fire only on the tick edge that loads the new coordinate.
    assign w_line_edge  = w_tick && (r_hpos == H_LAST);
    assign w_frame_edge = w_line_edge && (r_vpos == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + DIV_W'(1);
            r_hpos        <= w_h_next;
            r_vpos        <= w_v_next;
            r_hsync       <= !((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
            r_vsync       <= !((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
            r_display_on  <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
            r_line_start  <= w_line_edge;
            r_frame_start <= w_frame_edge;
            if (w_frame_edge) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign display_on  = r_display_on;
    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_game_vga_timing.sv
// Bench for game_vga_timing: four timing configurations checked every cycle
// against a closed-form raster model, plus literal spot checks and random resets.
module tb_game_vga_timing;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Edges seen since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    logic       a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic [7:0] a_fc;
    logic       b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] b_h, b_v;
    logic [7:0] b_fc;
    logic       c_hs, c_vs, c_de, c_ls, c_fs;
    logic [3:0] c_h, c_v;
    logic [7:0] c_fc;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [3:0] d_h, d_v;
    logic [7:0] d_fc;

    game_vga_timing u_a (
        .clk(clk), .rst_n(rst_n), .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
        .hpos(a_h), .vpos(a_v), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    game_vga_timing #(
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
        .hpos(b_h), .vpos(b_v), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    game_vga_timing #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(2), .POS_WIDTH(4)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .hsync(c_hs), .vsync(c_vs), .display_on(c_de),
        .hpos(c_h), .vpos(c_v), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc)
    );

    game_vga_timing #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(3), .POS_WIDTH(4)
    ) u_d (
        .clk(clk), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
        .hpos(d_h), .vpos(d_v), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    // Closed form: after n edges there have been n/div pixel ticks; the raster
    // index is (ticks-1) mod total, with the reset point being index total-1.
    function automatic logic [32:0] model(input int cyc, input int hd, input int hf,
                                          input int hs, input int hb, input int vd,
                                          input int vf, input int vs, input int vb,
                                          input int dv);
        int ht, vt, tot, t, lin, h, v, fc;
        logic ls, fs, hsy, vsy, de;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        tot = ht * vt;
        t   = cyc / dv;
        lin = (t + tot - 1) % tot;
        h   = lin % ht;
        v   = lin / ht;
        fc  = (t == 0) ? 0 : (((t - 1) / tot + 1) % 256);
        ls  = (cyc > 0) && (cyc % dv == 0) && (h == 0);
        fs  = ls && (v == 0);
        hsy = !((h >= hd + hf) && (h < hd + hf + hs));
        vsy = !((v >= vd + vf) && (v < vd + vf + vs));
        de  = (h < hd) && (v < vd);
        return {hsy, vsy, de, ls, fs, fc[7:0], h[9:0], v[9:0]};
    endfunction

    task automatic cmp_vec(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d act{hs,vs,de,ls,fs,fc,h,v}=%b,%b,%b,%b,%b,%0d,%0d,%0d exp=%b,%b,%b,%b,%b,%0d,%0d,%0d",
                     name, n, act[32], act[31], act[30], act[29], act[28], act[27:20],
                     act[19:10], act[9:0], exp[32], exp[31], exp[30], exp[29],
                     exp[28], exp[27:20], exp[19:10], exp[9:0]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cmp_vec("model_a", {a_hs, a_vs, a_de, a_ls, a_fs, a_fc, a_h, a_v},
                model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1));
        cmp_vec("model_b", {b_hs, b_vs, b_de, b_ls, b_fs, b_fc, b_h, b_v},
                model(n, 640, 16, 96, 48, 4, 1, 2, 1, 1));
        cmp_vec("model_c", {c_hs, c_vs, c_de, c_ls, c_fs, c_fc, 6'd0, c_h, 6'd0, c_v},
                model(n, 4, 1, 2, 1, 3, 1, 1, 1, 2));
        cmp_vec("model_d", {d_hs, d_vs, d_de, d_ls, d_fs, d_fc, 6'd0, d_h, 6'd0, d_v},
                model(n, 4, 1, 2, 1, 3, 1, 1, 1, 3));
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_a_hsync"}, int'(a_hs), 1);
        chk({tag, "_a_vsync"}, int'(a_vs), 1);
        chk({tag, "_a_hpos"}, int'(a_h), 799);
        chk({tag, "_a_vpos"}, int'(a_v), 524);
        chk({tag, "_a_de"}, int'(a_de), 0);
        chk({tag, "_a_fcnt"}, int'(a_fc), 0);
        chk({tag, "_c_hpos"}, int'(c_h), 7);
        chk({tag, "_c_vpos"}, int'(c_v), 5);
    endtask

    initial begin : stim
        int  hs_low, hs_first, de_cnt, a_ls_cnt, b_vs_low, b_fs_cnt, c_ls_cnt, c_fs_cnt;
        bit  done;
        int  waited;
        hs_low = 0; hs_first = -1; de_cnt = 0; a_ls_cnt = 0;
        b_vs_low = 0; b_fs_cnt = 0; c_ls_cnt = 0; c_fs_cnt = 0;
        done = 0;

        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_hpos", int'(a_h), 0);
        chk("first_vpos", int'(a_v), 0);
        chk("first_de", int'(a_de), 1);
        chk("first_fs", int'(a_fs), 1);
        chk("first_fcnt", int'(a_fc), 1);

        for (int k = 0; k < 26000 && !done; k++) begin
            if (n >= 1 && n <= 800) begin
                if (!a_hs) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(a_h);
                end
                if (a_de) de_cnt++;
                if (a_ls) a_ls_cnt++;
            end
            if (n == 801) begin
                chk("a_hsync_low_clks", hs_low, 96);
                chk("a_hsync_first_hpos", hs_first, 656);
                chk("a_display_clks", de_cnt, 640);
                chk("a_line_starts_in_line", a_ls_cnt, 1);
                chk("a_line_period_ls", int'(a_ls), 1);
                chk("a_line2_vpos", int'(a_v), 1);
            end
            if (n >= 1 && n <= 6400) begin
                if (!b_vs) b_vs_low++;
                if (b_fs) b_fs_cnt++;
            end
            if (n == 6401) begin
                chk("b_vsync_low_clks", b_vs_low, 1600);
                chk("b_frame_starts", b_fs_cnt, 1);
                chk("b_frame_period_fs", int'(b_fs), 1);
            end
            if (n >= 1 && n <= 96 && c_ls) c_ls_cnt++;
            if (n == 97) chk("c_line_start_clks", c_ls_cnt, 6);
            if (c_fs) begin
                c_fs_cnt++;
                if (c_fs_cnt == 255) chk("c_fcnt_255", int'(c_fc), 255);
                if (c_fs_cnt == 256) begin
                    chk("c_fcnt_wrap", int'(c_fc), 0);
                    chk("c_wrap_cycle", n, 2 + 96 * 255);
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        if (!done) chk("c_wrap_timeout", 0, 1);

        waited = 0;
        while (a_h != 10'd700 && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("a_reach_700", int'(a_h), 700);
        chk("a_hsync_low_at_700", int'(a_hs), 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 2000)) @(posedge clk);
            #($urandom_range(1, 4));
            rst_n = 1'b0;
            #1;
            check_reset_values("rnd");
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
        end

        repeat (300) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
